// File: rtl/regfile_pkg.sv
// Shared constants and state type for the MIPS register file.
// The optional same-cycle write-through is enabled by defining REGFILE_WR_BYPASS_EN.
`ifndef N_REG
`define N_REG 32
`endif
`ifndef N_REG_ADDR
`define N_REG_ADDR 5
`endif

package regfile_pkg;

  localparam int DATA_W   = `N_REG;
  localparam int ADDR_W   = `N_REG_ADDR;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero for r0, disabled reads and the init sweep.
// Defining REGFILE_WR_BYPASS_EN adds same-cycle forwarding of the write-back data.
module regfile_rd_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              i_ready,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_mem_data,
`ifdef REGFILE_WR_BYPASS_EN
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
`endif
  output logic [DATA_W-1:0] o_data
);

  // i_addr is known non-zero here, so a matching write address is too.
  always_comb begin
    o_data = '0;
    if (i_ready && i_ren && (i_addr != '0)) begin
      o_data = i_mem_data;
`ifdef REGFILE_WR_BYPASS_EN
      if (i_wen && (i_waddr == i_addr)) begin
        o_data = i_wdata;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file with a post-reset clearing sweep.
// Define REGFILE_WR_BYPASS_EN for write-through on the read ports.
module regfile #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_reg_0_ren,
  input  logic [ADDR_W-1:0] i_reg_0_addr,
  output logic [DATA_W-1:0] o_reg_0_data,
  input  logic              i_reg_1_ren,
  input  logic [ADDR_W-1:0] i_reg_1_addr,
  output logic [DATA_W-1:0] o_reg_1_data,
  output logic              o_ready,
  output logic              o_wr_drop
);

  import regfile_pkg::*;

  localparam int CNT_W = $clog2(NUM_REGS);

  rf_state_e          state_q, state_d;
  logic [CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic               ready_q, ready_d;
  logic               wr_drop_q, wr_drop_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem [NUM_REGS];

  logic [DATA_W-1:0]  rd_0_raw;
  logic [DATA_W-1:0]  rd_1_raw;
  logic               file_ready;

  // The sweep owns the write port during INIT; external writes are reported as dropped.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    wr_drop_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = i_waddr;
    mem_wdata  = i_wdata;
    case (state_q)
      RF_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ADDR_W'(init_cnt_q);
        mem_wdata = '0;
        wr_drop_d = i_wen;
        if (init_cnt_q == CNT_W'(NUM_REGS - 1)) begin
          state_d = RF_READY;
          ready_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + CNT_W'(1);
        end
      end
      RF_READY: begin
        mem_we = i_wen && (i_waddr != '0);
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RF_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // No reset on the array so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_0_raw   = mem[i_reg_0_addr];
  assign rd_1_raw   = mem[i_reg_1_addr];
  assign file_ready = (state_q == RF_READY);

  assign o_ready   = ready_q;
  assign o_wr_drop = wr_drop_q;

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port_0 (
    .i_ready    (file_ready),
    .i_ren      (i_reg_0_ren),
    .i_addr     (i_reg_0_addr),
    .i_mem_data (rd_0_raw),
`ifdef REGFILE_WR_BYPASS_EN
    .i_wen      (i_wen),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
`endif
    .o_data     (o_reg_0_data)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port_1 (
    .i_ready    (file_ready),
    .i_ren      (i_reg_1_ren),
    .i_addr     (i_reg_1_addr),
    .i_mem_data (rd_1_raw),
`ifdef REGFILE_WR_BYPASS_EN
    .i_wen      (i_wen),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
`endif
    .o_data     (o_reg_1_data)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random traffic,
// compared against an array-based model of the register file behaviour.
module tb_regfile;

  localparam int NUM = 32;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_wen;
  logic [4:0]  i_waddr;
  logic [31:0] i_wdata;
  logic        i_reg_0_ren;
  logic [4:0]  i_reg_0_addr;
  logic [31:0] o_reg_0_data;
  logic        i_reg_1_ren;
  logic [4:0]  i_reg_1_addr;
  logic [31:0] o_reg_1_data;
  logic        o_ready;
  logic        o_wr_drop;

  regfile dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_wen        (i_wen),
    .i_waddr      (i_waddr),
    .i_wdata      (i_wdata),
    .i_reg_0_ren  (i_reg_0_ren),
    .i_reg_0_addr (i_reg_0_addr),
    .o_reg_0_data (o_reg_0_data),
    .i_reg_1_ren  (i_reg_1_ren),
    .i_reg_1_addr (i_reg_1_addr),
    .o_reg_1_data (o_reg_1_data),
    .o_ready      (o_ready),
    .o_wr_drop    (o_wr_drop)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference state: register contents, edges left before ready, pending drop pulse.
  logic [31:0] model_mem [NUM];
  int          sweep_left;
  bit          exp_drop;
  int          checks;
  int          errors;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expRead(input bit ren, input logic [4:0] addr, input bit wen,
                                          input logic [4:0] waddr, input logic [31:0] wdata);
    if (!ren || addr == 5'd0 || sweep_left != 0) return 32'd0;
`ifdef REGFILE_WR_BYPASS_EN
    if (wen && waddr == addr) return wdata;
`endif
    return model_mem[addr];
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit wen, input logic [4:0] waddr, input logic [31:0] wdata,
                               input bit ren0, input logic [4:0] a0, input bit ren1, input logic [4:0] a1);
    bit rdy;
    i_wen        = wen;
    i_waddr      = waddr;
    i_wdata      = wdata;
    i_reg_0_ren  = ren0;
    i_reg_0_addr = a0;
    i_reg_1_ren  = ren1;
    i_reg_1_addr = a1;
    #1;
    rdy = (sweep_left == 0);
    checkOutput("ready", {31'd0, o_ready}, {31'd0, rdy});
    checkOutput("wr_drop", {31'd0, o_wr_drop}, {31'd0, exp_drop});
    checkOutput("rd0", o_reg_0_data, expRead(ren0, a0, wen, waddr, wdata));
    checkOutput("rd1", o_reg_1_data, expRead(ren1, a1, wen, waddr, wdata));
    @(posedge i_clk);
    if (!rdy) begin
      exp_drop = wen;
      sweep_left--;
    end else begin
      exp_drop = 1'b0;
      if (wen && waddr != 5'd0) model_mem[waddr] = wdata;
    end
    @(negedge i_clk);
  endtask

  // Called at a falling edge; asserts reset between edges and releases it at a falling edge.
  task automatic doReset();
    #2;
    i_rst_n = 1'b0;
    i_wen   = 1'b0;
    #1;
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("rst_drop", {31'd0, o_wr_drop}, 32'd0);
    sweep_left = NUM;
    exp_drop   = 1'b0;
    for (int i = 0; i < NUM; i++) model_mem[i] = 32'd0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    i_rst_n      = 1'b0;
    i_wen        = 1'b0;
    i_waddr      = '0;
    i_wdata      = '0;
    i_reg_0_ren  = 1'b0;
    i_reg_0_addr = '0;
    i_reg_1_ren  = 1'b0;
    i_reg_1_addr = '0;
    @(negedge i_clk);
    doReset();

    // Sweep with r5 reads on both ports and a write to r3 in the tenth cycle.
    for (int i = 0; i < NUM; i++)
      applyStimulus(i == 9, 5'd3, 32'hA5A5_A5A5, 1'b1, 5'd5, 1'b1, 5'd5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
    checkOutput("ready_after_sweep", {31'd0, o_ready}, 32'd1);

    applyStimulus(1'b1, 5'd1, 32'h0000_029A, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b1, 5'd1);

    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);

    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 1'b0, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3);

    applyStimulus(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0);
    doReset();
    for (int i = 0; i < NUM; i++)
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);

    // Random traffic, addresses biased low to force port and write collisions.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa, ra0, ra1;
      wa  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom,
                    ($urandom_range(0, 3) != 0), ra0, ($urandom_range(0, 3) != 0), ra1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
